// File: rtl/fetch_branch_unit.sv
// Fetch stage: PC register, IF/ID pipeline register and CBZ/B branch resolution with 1-bubble flush.
// Optional macro BRANCH_STATS_EN adds saturating TakenCount/NotTakenCount outputs.
module fetch_branch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stall,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic               Branch,
  input  logic               UncondBranch,
  input  logic               Zero,
  input  logic [ADDR_W-1:0]  BrOffset,
  output logic [ADDR_W-1:0]  PCout,
  output logic [ADDR_W-1:0]  IFID_PC,
  output logic [INSTR_W-1:0] IFID_Instr,
  output logic               IFID_Valid,
  output logic               PCSrc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        TakenCount,
  output logic [31:0]        NotTakenCount
`endif
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               taken;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  seq_pc;

  // A bubble in IF/ID must never redirect, whatever the decoder drives.
  assign taken  = ifid_valid_q & (UncondBranch | (Branch & Zero));
  assign target = ifid_pc_q + {BrOffset[ADDR_W-3:0], 2'b00};
  assign seq_pc = pc_q + ADDR_W'(4);

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (taken) begin
      pc_d         = target;
      ifid_pc_d    = pc_q;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      pc_d         = seq_pc;
      ifid_pc_d    = pc_q;
      ifid_instr_d = InstrIn;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign PCout      = pc_q;
  assign IFID_PC    = ifid_pc_q;
  assign IFID_Instr = ifid_instr_q;
  assign IFID_Valid = ifid_valid_q;
  assign PCSrc      = taken;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] ntaken_cnt_q, ntaken_cnt_d;
  logic        not_taken;

  assign not_taken = ifid_valid_q & Branch & ~Zero & ~UncondBranch & ~Stall;

  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (taken && (taken_cnt_q != 32'hFFFF_FFFF)) taken_cnt_d = taken_cnt_q + 32'd1;
    if (not_taken && (ntaken_cnt_q != 32'hFFFF_FFFF)) ntaken_cnt_d = ntaken_cnt_q + 32'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign TakenCount    = taken_cnt_q;
  assign NotTakenCount = ntaken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Scoreboard bench for fetch_branch_unit: driver pushes model expectations, monitor pops and compares.
module tb_fetch_branch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stall;
  logic [31:0] InstrIn;
  logic        Branch;
  logic        UncondBranch;
  logic        Zero;
  logic [63:0] BrOffset;
  logic [63:0] PCout;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic        PCSrc;
`ifdef BRANCH_STATS_EN
  logic [31:0] TakenCount;
  logic [31:0] NotTakenCount;
`endif

  fetch_branch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'd0)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .InstrIn(InstrIn),
    .Branch(Branch), .UncondBranch(UncondBranch), .Zero(Zero), .BrOffset(BrOffset),
    .PCout(PCout), .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid),
    .PCSrc(PCSrc)
`ifdef BRANCH_STATS_EN
    , .TakenCount(TakenCount), .NotTakenCount(NotTakenCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        pcsrc;
    logic [63:0] pc;
    logic [63:0] ifid_pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] tc;
    logic [31:0] ntc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Architectural view of the fetch stage as the specification states it.
  logic [63:0] m_pc, m_ifid_pc;
  logic [31:0] m_instr, m_tc, m_ntc;
  logic        m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_ifid_pc = 64'd0; m_instr = 32'd0; m_valid = 1'b0;
    m_tc = 32'd0; m_ntc = 32'd0;
  endtask

  // Apply one cycle of inputs (called right after a falling edge) and queue the expected result.
  task automatic drive(input logic st, input logic br, input logic ub, input logic z,
                       input logic [63:0] off, input logic [31:0] ins);
    exp_t e;
    logic tk;
    Stall = st; Branch = br; UncondBranch = ub; Zero = z; BrOffset = off; InstrIn = ins;
    tk = m_valid && (ub || (br && z));
    e.pcsrc = tk;
    if (tk) begin
      m_ifid_pc = m_pc;
      m_pc      = e.pcsrc ? (IFID_PC_model_target(off)) : m_pc;
      m_instr   = 32'd0;
      m_valid   = 1'b0;
      if (m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 1;
    end else begin
      if (m_valid && br && !z && !ub && !st && m_ntc != 32'hFFFF_FFFF) m_ntc = m_ntc + 1;
      if (!st) begin
        m_ifid_pc = m_pc;
        m_pc      = m_pc + 64'd4;
        m_instr   = ins;
        m_valid   = 1'b1;
      end
    end
    e.pc = m_pc; e.ifid_pc = m_ifid_pc; e.instr = m_instr; e.valid = m_valid;
    e.tc = m_tc; e.ntc = m_ntc;
    exp_q.push_back(e);
  endtask

  // Target is computed from the IF/ID PC as it was before this edge.
  logic [63:0] pre_ifid_pc;
  function automatic logic [63:0] IFID_PC_model_target(input logic [63:0] off);
    return pre_ifid_pc + off * 64'd4;
  endfunction

  task automatic step(input logic st, input logic br, input logic ub, input logic z,
                      input logic [63:0] off, input logic [31:0] ins);
    @(negedge Clock);
    pre_ifid_pc = m_ifid_pc;
    drive(st, br, ub, z, off, ins);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_PCout"}, PCout, 64'd0);
    chk({tag, "_IFID_PC"}, IFID_PC, 64'd0);
    chk({tag, "_IFID_Instr"}, {32'd0, IFID_Instr}, 64'd0);
    chk({tag, "_IFID_Valid"}, {63'd0, IFID_Valid}, 64'd0);
    chk({tag, "_PCSrc"}, {63'd0, PCSrc}, 64'd0);
  endtask

  // Monitor: PCSrc is checked mid-cycle, registered state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      #3;
      if (exp_q.size() > 0) begin
        chk("PCSrc", {63'd0, PCSrc}, {63'd0, exp_q[0].pcsrc});
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        chk("PCout", PCout, e.pc);
        chk("IFID_PC", IFID_PC, e.ifid_pc);
        chk("IFID_Instr", {32'd0, IFID_Instr}, {32'd0, e.instr});
        chk("IFID_Valid", {63'd0, IFID_Valid}, {63'd0, e.valid});
`ifdef BRANCH_STATS_EN
        chk("TakenCount", {32'd0, TakenCount}, {32'd0, e.tc});
        chk("NotTakenCount", {32'd0, NotTakenCount}, {32'd0, e.ntc});
`endif
      end
    end
  end

  initial begin
    logic [63:0] off;
    int sel;
    Reset = 1'b1; Stall = 1'b0; Branch = 1'b0; UncondBranch = 1'b0; Zero = 1'b0;
    BrOffset = 64'd0; InstrIn = 32'd0;
    model_reset();
    pre_ifid_pc = 64'd0;
    #3;
    check_reset_outputs("rst");
    @(negedge Clock);
    Reset = 1'b0;
    pre_ifid_pc = m_ifid_pc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0004);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0008);
    // CBZ taken at IFID_PC=8 with offset 3, then its bubble with branch inputs high
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'd3, 32'hDEAD_0001);
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'd3, 32'hA000_0014);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0018);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd3, 32'hA000_001C);
    // Unconditional backward branch, plain and under stall
    step(1'b0, 1'b0, 1'b1, 1'b0, -64'sd2, 32'hDEAD_0002);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0020);
    step(1'b1, 1'b0, 1'b1, 1'b0, -64'sd2, 32'hDEAD_0003);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0024);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 32'hDEAD_0004);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd5, 32'hDEAD_0005);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'd1, 32'hDEAD_0006);
    // Redirect to the top word, then step across the wrap to 0
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0028);
    @(negedge Clock);
    pre_ifid_pc = m_ifid_pc;
    off = (64'hFFFF_FFFF_FFFF_FFFC - m_ifid_pc) >> 2;
    drive(1'b0, 1'b0, 1'b1, 1'b0, off, 32'hDEAD_0007);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_002C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hA000_0030);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        // Asynchronous reset pulse between edges
        @(negedge Clock);
        #1 Reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        pre_ifid_pc = m_ifid_pc;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 64'd1, 32'h1234_5678);
        #2 Reset = 1'b0;
      end else begin
        sel = $urandom_range(0, 3);
        off = (sel == 0) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 16)) - 8);
        step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, off, $urandom);
      end
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge Clock);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
